// File: rtl/run_ctrl.sv
// run_ctrl: CPU reset/run sequencer with cycle budget, halt drain window and end-cause status.
// Optional RUN_CTRL_DEBUG_EN: simulation-only report of the end cause, then $finish.
module run_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32,
  parameter int NUM_HALT     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    timeout_lim,
  input  logic [NUM_HALT-1:0] halt_req,
  output logic                cpu_rst,
  output logic                running,
  output logic                done,
  output logic                timed_out,
  output logic [NUM_HALT-1:0] halt_src,
  output logic [CNT_W-1:0]    cycle_cnt
);
  localparam int SMAX = RST_CYCLES > DRAIN_CYCLES ? RST_CYCLES : DRAIN_CYCLES;
  localparam int SW = SMAX > 1 ? $clog2(SMAX) : 1;
  localparam logic [SW-1:0] RST_LAST = SW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] DRAIN_LAST = SW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] sub;
  logic [CNT_W-1:0] lim, cnt_inc;
  logic halt, hit, go;

  assign halt = |halt_req;
  assign cnt_inc = cycle_cnt + 1'b1;
  assign hit = lim != '0 && cnt_inc == lim;
  assign go = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE, DONE: nxt = start ? RESET : state;
        RESET:      nxt = sub == RST_LAST ? RUN : RESET;
        RUN:        nxt = halt ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : hit ? DONE : RUN;
        DRAIN:      nxt = sub == DRAIN_LAST ? DONE : DRAIN;
        default:    nxt = IDLE;
      endcase
  end

  always_comb begin
    cpu_rst = state == IDLE || state == RESET || state == DONE;
    running = state == RUN || state == DRAIN;
    done = state == DONE;
  end

  // Halt takes priority over timeout and freezes the count on the halting edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sub <= '0;
      lim <= '0;
      timed_out <= 1'b0;
      halt_src <= '0;
      cycle_cnt <= '0;
    end else if (abort || go) begin
      sub <= '0;
      lim <= abort ? '0 : timeout_lim;
      timed_out <= 1'b0;
      halt_src <= '0;
      cycle_cnt <= '0;
    end else begin
      sub <= (nxt == state && (state == RESET || state == DRAIN)) ? sub + 1'b1 : '0;
      if (state == RUN) begin
        if (halt) halt_src <= halt_req;
        else begin
          cycle_cnt <= &cycle_cnt ? cycle_cnt : cnt_inc;
          timed_out <= hit;
        end
      end
    end

`ifdef RUN_CTRL_DEBUG_EN
  logic dbg_prev, dbg_fin;
  always @(posedge clk) begin
    if (dbg_fin) $finish;
    if (done && !dbg_prev)
      $display("run_ctrl: cycle_cnt=%0d timed_out=%0b halt_src=%b", cycle_cnt, timed_out, halt_src);
    dbg_fin <= done && !dbg_prev;
    dbg_prev <= done;
  end
`endif
endmodule
